// File: rtl/fpnew_pkg.sv
// Shared FPU types: only the exception-flag struct is used by the response buffer.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_resp_buffer.sv
// Response FIFO between the FPU output and a consumer: registered head, no ready/valid feedthrough.
// Optional sticky flag accumulator enabled by defining FPNEW_RESP_FFLAGS_EN.
module fpnew_resp_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter type         TagType = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [WIDTH-1:0]             fpu_result_i,
    input  status_t                      fpu_status_i,
    input  TagType                       fpu_tag_i,
    input  logic                         fpu_valid_i,
    output logic                         fpu_ready_o,
    output logic [WIDTH-1:0]             result_o,
    output status_t                      status_o,
    output TagType                       tag_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
`ifdef FPNEW_RESP_FFLAGS_EN
    ,
    output status_t                      fflags_o,
    input  logic                         fflags_clr_i
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        status_t          status;
        TagType           tag;
    } entry_t;

    if (DEPTH < 2 || DEPTH > 16) begin : gen_depth_check
        $error("fpnew_resp_buffer: DEPTH must be in 2..16");
    end

    entry_t mem_q [DEPTH];
    entry_t head;
    ptr_t   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t   count_q, count_d;
    logic   push, pop, full, empty;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full  = (count_q == cnt_t'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = fpu_valid_i & ~full & ~flush_i;
    assign pop   = ~empty & ready_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; it is only visible through valid_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign result_o    = head.result;
    assign status_o    = head.status;
    assign tag_o       = head.tag;
    assign valid_o     = ~empty;
    assign fpu_ready_o = ~full;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;

`ifdef FPNEW_RESP_FFLAGS_EN
    status_t fflags_q, fflags_d;

    always_comb begin
        fflags_d = status_t'((fflags_clr_i ? '0 : fflags_q) | (pop ? head.status : '0));
    end

    // Sticky flags survive a flush; only reset or an explicit clear drops them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_o = fflags_q;
`endif

endmodule

// File: tb/tb_fpnew_resp_buffer.sv
// Self-checking bench for fpnew_resp_buffer against a queue-based reference model.
module tb_fpnew_resp_buffer;
    import fpnew_pkg::*;

    localparam int Depth = 4;
    typedef logic [3:0] tag_t;
    typedef struct packed {
        logic [63:0] r;
        logic [4:0]  s;
        tag_t        t;
    } ent_t;

    logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
    logic        fpu_valid_i = 1'b0, ready_i = 1'b0, fflags_clr_i = 1'b0;
    logic [63:0] fpu_result_i = '0;
    status_t     fpu_status_i = '0;
    tag_t        fpu_tag_i = '0;
    logic        fpu_ready_o, valid_o, full_o, empty_o;
    logic [63:0] result_o;
    status_t     status_o;
    tag_t        tag_o;
    logic [2:0]  count_o;
    status_t     fflags_o;

    fpnew_resp_buffer #(.WIDTH(64), .DEPTH(Depth), .TagType(tag_t)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .fpu_result_i (fpu_result_i),
        .fpu_status_i (fpu_status_i),
        .fpu_tag_i    (fpu_tag_i),
        .fpu_valid_i  (fpu_valid_i),
        .fpu_ready_o  (fpu_ready_o),
        .result_o     (result_o),
        .status_o     (status_o),
        .tag_o        (tag_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
`ifdef FPNEW_RESP_FFLAGS_EN
        ,
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i)
`endif
    );

`ifndef FPNEW_RESP_FFLAGS_EN
    assign fflags_o = '0;
`endif

    always #5 clk_i = ~clk_i;

    ent_t       q[$];
    logic [4:0] m_fflags = '0;
    int         total = 0;
    int         bad = 0;

    // Drive one cycle of stimulus and advance the model; returns 2 time units after the edge.
    task automatic cyc(input logic v, input logic [63:0] r, input logic [4:0] s, input tag_t t,
                       input logic rdy, input logic fl, input logic clr);
        logic dp, dq;
        ent_t h;
        fpu_valid_i  = v;
        fpu_result_i = r;
        fpu_status_i = status_t'(s);
        fpu_tag_i    = t;
        ready_i      = rdy;
        flush_i      = fl;
        fflags_clr_i = clr;
        dp = v && (q.size() < Depth) && !fl;
        dq = (q.size() > 0) && rdy && !fl;
        h  = dq ? q[0] : '0;
        @(posedge clk_i);
        m_fflags = (clr ? 5'b0 : m_fflags) | (dq ? h.s : 5'b0);
        if (fl) q.delete();
        else begin
            if (dq) void'(q.pop_front());
            if (dp) q.push_back('{r: r, s: s, t: t});
        end
        #2;
        fpu_valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; fflags_clr_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (fpu_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", fpu_ready_o); end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty_o); end
        total++; if (full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", valid_o); end
    endtask

    task automatic test_single();
        cyc(1'b1, 64'h3FF0000000000000, 5'b00001, 4'd1, 1'b1, 1'b0, 1'b0);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", valid_o); end
        total++; if (result_o !== 64'h3FF0000000000000) begin bad++; $display("FAIL single_result got=%h want=3ff0000000000000", result_o); end
        total++; if (5'(status_o) !== 5'b00001) begin bad++; $display("FAIL single_status got=%b want=00001", status_o); end
        total++; if (tag_o !== 4'd1) begin bad++; $display("FAIL single_tag got=%0d want=1", tag_o); end
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (empty_o !== 1'b1 || valid_o !== 1'b0) begin bad++; $display("FAIL single_empty got=%b/%b want=1/0", empty_o, valid_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'(i), '0, tag_t'(i), 1'b0, 1'b0, 1'b0);
        total++; if (count_o !== 3'd4 || full_o !== 1'b1) begin bad++; $display("FAIL fill_full got=%0d/%b want=4/1", count_o, full_o); end
        total++; if (fpu_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", fpu_ready_o); end
        total++; if (result_o !== 64'd0) begin bad++; $display("FAIL fill_head got=%0d want=0", result_o); end
        // Pop while full: the held fifth value must not slip in on the same edge.
        cyc(1'b1, 64'd4, '0, 4'd4, 1'b1, 1'b0, 1'b0);
        total++; if (count_o !== 3'd3 || fpu_ready_o !== 1'b1) begin bad++; $display("FAIL fill_popfull got=%0d/%b want=3/1", count_o, fpu_ready_o); end
        cyc(1'b1, 64'd4, '0, 4'd4, 1'b0, 1'b0, 1'b0);
        total++; if (count_o !== 3'd4) begin bad++; $display("FAIL fill_fifth got=%0d want=4", count_o); end
        for (int k = 1; k < 5; k++) begin
            total++; if (valid_o !== 1'b1 || result_o !== 64'(k)) begin bad++; $display("FAIL fill_order got=%0d want=%0d", result_o, k); end
            cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL fill_drained got=%b want=1", empty_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) cyc(1'b1, {$urandom, $urandom}, 5'($urandom), tag_t'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            total++; if (result_o !== q[0].r || tag_o !== q[0].t) begin bad++; $display("FAIL b2b_head got=%h want=%h", result_o, q[0].r); end
            cyc(1'b1, {$urandom, $urandom}, 5'($urandom), tag_t'($urandom), 1'b1, 1'b0, 1'b0);
            total++; if (count_o !== 3'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", count_o); end
        end
        for (int i = 0; i < 2; i++) begin
            total++; if (result_o !== q[0].r || 5'(status_o) !== q[0].s) begin bad++; $display("FAIL b2b_tail got=%h want=%h", result_o, q[0].r); end
            cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'(100 + i), '0, tag_t'(i), 1'b0, 1'b0, 1'b0);
        total++; if (count_o !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d want=3", count_o); end
        cyc(1'b1, 64'hDEAD, 5'b11111, 4'hF, 1'b1, 1'b1, 1'b0);
        total++; if (count_o !== 3'd0 || empty_o !== 1'b1) begin bad++; $display("FAIL flush_count got=%0d want=0", count_o); end
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b want=0", valid_o); end
        cyc(1'b1, 64'h55, 5'b00010, 4'd7, 1'b0, 1'b0, 1'b0);
        total++; if (result_o !== 64'h55 || tag_o !== 4'd7) begin bad++; $display("FAIL flush_resume got=%h want=55", result_o); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom), tag_t'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) == 0));
            total++; if (count_o !== 3'(q.size())) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", count_o, q.size()); end
            total++; if (valid_o !== (q.size() > 0) || fpu_ready_o !== (q.size() < Depth)) begin bad++; $display("FAIL rnd_flags got=%b/%b size=%0d", valid_o, fpu_ready_o, q.size()); end
            if (q.size() > 0) begin
                total++; if (result_o !== q[0].r || 5'(status_o) !== q[0].s || tag_o !== q[0].t) begin bad++; $display("FAIL rnd_head got=%h want=%h", result_o, q[0].r); end
            end
`ifdef FPNEW_RESP_FFLAGS_EN
            total++; if (5'(fflags_o) !== m_fflags) begin bad++; $display("FAIL rnd_fflags got=%b want=%b", fflags_o, m_fflags); end
`endif
        end
        drain();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) cyc(1'b1, 64'(i + 9), '0, '0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        total++; if (count_o !== 3'd0 || valid_o !== 1'b0 || empty_o !== 1'b1 || fpu_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_async got=%0d/%b want=0/0", count_o, valid_o); end
        q.delete();
        m_fflags = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1'b1, 64'hABCD, 5'b00100, 4'd3, 1'b0, 1'b0, 1'b0);
        total++; if (count_o !== 3'd1 || result_o !== 64'hABCD) begin bad++; $display("FAIL midrst_resume got=%0d/%h want=1/abcd", count_o, result_o); end
        drain();
    endtask

`ifdef FPNEW_RESP_FFLAGS_EN
    task automatic test_fflags();
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 64'd1, 5'b10000, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'd2, 5'b00100, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (5'(fflags_o) !== 5'b10100) begin bad++; $display("FAIL fflags_accum got=%b want=10100", fflags_o); end
        cyc(1'b1, 64'd3, 5'b01000, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        total++; if (5'(fflags_o) !== 5'b01000) begin bad++; $display("FAIL fflags_clr got=%b want=01000", fflags_o); end
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        total++; if (5'(fflags_o) !== m_fflags) begin bad++; $display("FAIL fflags_flush got=%b want=%b", fflags_o, m_fflags); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flush();
        test_random();
        test_mid_reset();
`ifdef FPNEW_RESP_FFLAGS_EN
        test_fflags();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
